// File: rtl/buffered_serial_transmitter_if.sv
// ---------------------------------------------------------------------------
// buffered_serial_transmitter_if
//   Bundles the producer-side handshake and the transmitter status/line
//   outputs of buffered_serial_transmitter.
//
//   tx_data            word to queue (DATA_BITS wide)
//   tx_data_available  one-cycle write strobe
//   tx_ready           FIFO not full; writes are accepted only while high
//   serial_tx          serial line, idles high
//   tx_busy            frame in progress or words still queued
//   fifo_count         queued words not yet started
//
//   master : the producer (drives data/strobe, observes status)
//   slave  : the transmitter
// ---------------------------------------------------------------------------
interface buffered_serial_transmitter_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_data_available;
  logic                 tx_ready;
  logic                 serial_tx;
  logic                 tx_busy;
  logic [CW-1:0]        fifo_count;

  modport master (
    output tx_data, tx_data_available,
    input  tx_ready, serial_tx, tx_busy, fifo_count
  );

  modport slave (
    input  tx_data, tx_data_available,
    output tx_ready, serial_tx, tx_busy, fifo_count
  );
endinterface

// File: rtl/buffered_serial_transmitter.sv
// ---------------------------------------------------------------------------
// buffered_serial_transmitter
//   UART-style transmitter with a transmit FIFO. Words written through the
//   bus interface are queued and sent in arrival order as
//   start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop
//   frames, each bit lasting CLOCKS_PER_BIT cycles. Consecutive queued words
//   are sent back-to-back with no idle gap.
//
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave side of buffered_serial_transmitter_if
//            (tx_data, tx_data_available in; tx_ready, serial_tx, tx_busy,
//             fifo_count out)
//
//   The bus interface instance must be built with the same DATA_BITS and
//   FIFO_DEPTH as this module.
// ---------------------------------------------------------------------------
module buffered_serial_transmitter #(
  parameter int CLOCKS_PER_BIT = 5000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                          clock,
  input logic                          reset_n,
  buffered_serial_transmitter_if.slave bus
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 4;  // indexes up to 9 data bits
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLOCKS_PER_BIT - 1);

  if (CLOCKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("buffered_serial_transmitter: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_e;

  state_e               state_q,     state_d;
  logic [TW-1:0]        timer_q,     timer_d;
  logic [BW-1:0]        bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 parity_q,    parity_d;
  logic                 serial_tx_q, serial_tx_d;
  logic [AW-1:0]        wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]        count_q,     count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 full, push, pop, load_frame, bit_done;
  logic [DATA_BITS-1:0] head;

  assign head     = mem_q[rd_ptr_q];
  assign bit_done = (timer_q == '0);

  // FIFO bookkeeping. Fullness comes from the registered count only, so a
  // pop in the same cycle never frees room for a push into a full queue.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    push     = bus.tx_data_available && !full;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Frame sequencer. serial_tx_d carries the level of the bit that starts
  // at the next edge, so the line comes straight from a flop.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    serial_tx_d = serial_tx_q;
    pop         = 1'b0;
    load_frame  = 1'b0;

    if (state_q != ST_IDLE) timer_d = bit_done ? TIMER_MAX : timer_q - TW'(1);

    case (state_q)
      ST_IDLE: begin
        serial_tx_d = 1'b1;
        if (count_q != '0) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d     = ST_DATA;
          bit_idx_d   = '0;
          serial_tx_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d     = ST_PARITY;
              serial_tx_d = parity_q;
            end else begin
              state_d     = ST_STOP;
              serial_tx_d = 1'b1;
            end
          end else begin
            bit_idx_d   = bit_idx_q + BW'(1);
            shift_d     = shift_q >> 1;
            serial_tx_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d     = ST_STOP;
          bit_idx_d   = '0;
          serial_tx_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_idx_q == BW'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when work is queued.
            if (count_q != '0) begin
              load_frame = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              serial_tx_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        serial_tx_d = 1'b1;
      end
    endcase

    if (load_frame) begin
      pop         = 1'b1;
      shift_d     = head;
      parity_d    = (PARITY == 1) ? ~^head : ^head;
      timer_d     = TIMER_MAX;
      state_d     = ST_START;
      serial_tx_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      serial_tx_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      serial_tx_q <= serial_tx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; a slot is only read after
  // it has been written, and leaving it reset-free lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  assign bus.tx_ready   = !full;
  assign bus.serial_tx  = serial_tx_q;
  assign bus.tx_busy    = (state_q != ST_IDLE) || (count_q != '0);
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_buffered_serial_transmitter.sv
// ---------------------------------------------------------------------------
// tb_buffered_serial_transmitter
//   Six transmitter instances in different configurations share one clock
//   and reset. Directed writes push the expected word into a per-instance
//   queue; a monitor process decodes every frame cycle by cycle against a
//   bit pattern built from that word and reports each frame once.
//     u0 defaults (5000 clk/bit, 8N1, depth 4)
//     u1 4 clk/bit, 8N1, depth 4          (burst / full)
//     u2 4 clk/bit, 7 bits, even parity
//     u3 4 clk/bit, 7 bits, odd parity
//     u4 4 clk/bit, 8 bits, two stop bits
//     u5 4 clk/bit, 8N1, depth 2          (simultaneous push/pop)
// ---------------------------------------------------------------------------
module tb_buffered_serial_transmitter;

  localparam int N_DUT = 6;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Per-instance frame format seen by the monitor model.
  int cpb_a  [N_DUT] = '{5000, 4, 4, 4, 4, 4};
  int nb_a   [N_DUT] = '{8, 8, 7, 7, 8, 8};
  int par_a  [N_DUT] = '{0, 0, 2, 1, 0, 0};
  int stop_a [N_DUT] = '{1, 1, 1, 1, 2, 1};

  logic [7:0] drv_data [N_DUT];
  logic       drv_av   [N_DUT];
  wire  [N_DUT-1:0] line_w, rdy_w, busy_w;
  wire  [3:0]       cnt_w [N_DUT];

  buffered_serial_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
  buffered_serial_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
  buffered_serial_transmitter_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if2 ();
  buffered_serial_transmitter_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if3 ();
  buffered_serial_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if4 ();
  buffered_serial_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(2)) if5 ();

  buffered_serial_transmitter u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
  buffered_serial_transmitter #(.CLOCKS_PER_BIT(4)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));
  buffered_serial_transmitter #(.CLOCKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2));
  buffered_serial_transmitter #(.CLOCKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1)) u3 (.clock(clock), .reset_n(reset_n), .bus(if3));
  buffered_serial_transmitter #(.CLOCKS_PER_BIT(4), .STOP_BITS(2)) u4 (.clock(clock), .reset_n(reset_n), .bus(if4));
  buffered_serial_transmitter #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(2)) u5 (.clock(clock), .reset_n(reset_n), .bus(if5));

  assign if0.tx_data = drv_data[0];       assign if0.tx_data_available = drv_av[0];
  assign if1.tx_data = drv_data[1];       assign if1.tx_data_available = drv_av[1];
  assign if2.tx_data = drv_data[2][6:0];  assign if2.tx_data_available = drv_av[2];
  assign if3.tx_data = drv_data[3][6:0];  assign if3.tx_data_available = drv_av[3];
  assign if4.tx_data = drv_data[4];       assign if4.tx_data_available = drv_av[4];
  assign if5.tx_data = drv_data[5];       assign if5.tx_data_available = drv_av[5];

  assign line_w = {if5.serial_tx, if4.serial_tx, if3.serial_tx, if2.serial_tx, if1.serial_tx, if0.serial_tx};
  assign rdy_w  = {if5.tx_ready,  if4.tx_ready,  if3.tx_ready,  if2.tx_ready,  if1.tx_ready,  if0.tx_ready};
  assign busy_w = {if5.tx_busy,   if4.tx_busy,   if3.tx_busy,   if2.tx_busy,   if1.tx_busy,   if0.tx_busy};
  assign cnt_w[0] = {1'b0, if0.fifo_count};
  assign cnt_w[1] = {1'b0, if1.fifo_count};
  assign cnt_w[2] = {1'b0, if2.fifo_count};
  assign cnt_w[3] = {1'b0, if3.fifo_count};
  assign cnt_w[4] = {1'b0, if4.fifo_count};
  assign cnt_w[5] = {2'b0, if5.fifo_count};

  // Scoreboard and monitor bookkeeping.
  logic [7:0]  exp_q [N_DUT][$];
  int          frames_done [N_DUT];
  int          starts      [N_DUT];
  int unsigned first_start [N_DUT];
  int unsigned last_start  [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected line level for each bit slot of a frame: start, data LSB
  // first, optional parity, then stop bits (remaining slots stay high).
  function automatic logic [15:0] frame_bits(input int nb, input int par, input logic [7:0] d);
    logic [15:0] s;
    logic        p;
    int          k;
    s = '1;
    p = 1'b0;
    s[0] = 1'b0;
    k = 1;
    for (int j = 0; j < nb; j++) begin
      s[k] = d[j];
      p    = p ^ d[j];
      k++;
    end
    if (par == 2) s[k] = p;
    else if (par == 1) s[k] = ~p;
    return s;
  endfunction

  // Monitor: samples every line on the falling clock edge.
  logic        rx_act  [N_DUT];
  logic        rx_skip [N_DUT];
  int          rx_pos  [N_DUT];
  int          rx_len  [N_DUT];
  int          rx_bad  [N_DUT];
  logic [7:0]  rx_word [N_DUT];
  logic [15:0] rx_seq  [N_DUT];

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      rx_act[i] = 1'b0; frames_done[i] = 0; starts[i] = 0;
      first_start[i] = 0; last_start[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < N_DUT; i++) begin
        if (!reset_n) begin
          rx_act[i] = 1'b0;     // frame aborted by reset
        end else begin
          if (!rx_act[i] && line_w[i] == 1'b0) begin
            check($sformatf("frame_start_expected_u%0d", i), 32'(exp_q[i].size() != 0), 1);
            rx_skip[i] = (exp_q[i].size() == 0);
            rx_word[i] = rx_skip[i] ? 8'h00 : exp_q[i].pop_front();
            rx_seq[i]  = frame_bits(nb_a[i], par_a[i], rx_word[i]);
            rx_len[i]  = cpb_a[i] * (1 + nb_a[i] + (par_a[i] != 0 ? 1 : 0) + stop_a[i]);
            rx_pos[i]  = 0;
            rx_bad[i]  = 0;
            rx_act[i]  = 1'b1;
            if (starts[i] == 0) first_start[i] = cyc;
            last_start[i] = cyc;
            starts[i]++;
          end
          if (rx_act[i]) begin
            if (!rx_skip[i] && line_w[i] !== rx_seq[i][rx_pos[i] / cpb_a[i]]) rx_bad[i]++;
            rx_pos[i]++;
            if (rx_pos[i] == rx_len[i]) begin
              if (!rx_skip[i])
                check($sformatf("frame_u%0d_word_%0h_bad_samples", i, rx_word[i]), rx_bad[i], 0);
              frames_done[i]++;
              rx_act[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  int unsigned acc_cyc;

  // Called 1 ns after a rising edge; the write is presented for the next edge.
  task automatic write_word(input int idx, input logic [7:0] d, input logic exp_ready, input logic to_sb);
    drv_data[idx] = d;
    drv_av[idx]   = 1'b1;
    check($sformatf("ready_before_write_u%0d_%0h", idx, d), rdy_w[idx], exp_ready);
    if (exp_ready && to_sb) exp_q[idx].push_back(d);
    @(posedge clock);
    #1;
    acc_cyc     = cyc;
    drv_av[idx] = 1'b0;
  endtask

  task automatic measure_busy(input int idx, input int exp_cycles);
    int n = 0;
    while (busy_w[idx] && n < exp_cycles + 20) begin
      n++;
      @(posedge clock);
      #1;
    end
    check($sformatf("busy_cycles_u%0d", idx), n, exp_cycles);
  endtask

  task automatic wait_frames(input int idx, input int target, input int budget);
    int n = 0;
    while (frames_done[idx] < target && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check($sformatf("frames_done_u%0d", idx), frames_done[idx], target);
  endtask

  int unsigned a1;
  int          lows;

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      drv_data[i] = '0;
      drv_av[i]   = 1'b0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("reset_serial_u%0d", i), line_w[i], 1);
      check($sformatf("reset_ready_u%0d", i),  rdy_w[i],  1);
      check($sformatf("reset_busy_u%0d", i),   busy_w[i], 0);
      check($sformatf("reset_count_u%0d", i),  cnt_w[i],  0);
    end
    #19 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Burst: 0x01 starts at once, 0x02..0x05 fill the queue, 0x06 dropped.
    for (int k = 1; k <= 6; k++) begin
      write_word(1, 8'(k), k != 6, 1'b1);
      if (k == 1) a1 = acc_cyc;
      if (k >= 5) check($sformatf("burst_count_after_%0d", k), cnt_w[1], 4);
    end
    check("burst_ready_when_full", rdy_w[1], 0);
    wait_frames(1, 5, 400);
    check("burst_first_start_latency", first_start[1] - a1, 1);
    check("burst_contiguous_span", last_start[1] - first_start[1], 160);
    check("burst_busy_last_cycle", busy_w[1], 1);
    @(posedge clock);
    #1;
    check("burst_end_busy", busy_w[1], 0);
    check("burst_end_serial", line_w[1], 1);
    check("burst_end_ready", rdy_w[1], 1);

    // Parity: even 0x07 -> 1, odd 0x07 -> 0, even 0x00 -> 0; 40-cycle frames.
    write_word(2, 8'h07, 1'b1, 1'b1);
    measure_busy(2, 41);
    write_word(3, 8'h07, 1'b1, 1'b1);
    measure_busy(3, 41);
    write_word(2, 8'h00, 1'b1, 1'b1);
    measure_busy(2, 41);
    wait_frames(2, 2, 20);
    wait_frames(3, 1, 20);

    // Two stop bits, back-to-back: start bits 44 cycles apart (8 high between).
    write_word(4, 8'h00, 1'b1, 1'b1);
    a1 = acc_cyc;
    write_word(4, 8'h00, 1'b1, 1'b1);
    measure_busy(4, 88);
    wait_frames(4, 2, 20);
    check("stop2_first_start_latency", first_start[4] - a1, 1);
    check("stop2_start_spacing", last_start[4] - first_start[4], 44);

    // Depth 2: push on the same edge as the STOP->START pop.
    write_word(5, 8'h5A, 1'b1, 1'b1);
    a1 = acc_cyc;
    write_word(5, 8'hC3, 1'b1, 1'b1);
    check("pp_count_after_second", cnt_w[5], 1);
    repeat (39) @(posedge clock);
    #1;
    check("pp_count_before_pop", cnt_w[5], 1);
    check("pp_serial_in_stop", line_w[5], 1);
    write_word(5, 8'h3C, 1'b1, 1'b1);
    check("pp_count_after_pushpop", cnt_w[5], 1);
    check("pp_ready_after_pushpop", rdy_w[5], 1);
    wait_frames(5, 3, 200);
    check("pp_first_start_latency", first_start[5] - a1, 1);
    check("pp_start_span", last_start[5] - first_start[5], 80);

    // Defaults: single 0xAB frame, 1-cycle latency, busy for 50001 cycles.
    write_word(0, 8'hAB, 1'b1, 1'b1);
    a1 = acc_cyc;
    measure_busy(0, 50001);
    wait_frames(0, 1, 20);
    check("single_first_start_latency", first_start[0] - a1, 1);

    // Reset during data bit 3 of 0xAB with 0x00 queued behind it.
    write_word(0, 8'hAB, 1'b1, 1'b1);
    write_word(0, 8'h00, 1'b1, 1'b0);
    repeat (22000) @(posedge clock);
    #2;
    check("midframe_count_before_reset", cnt_w[0], 1);
    check("midframe_busy_before_reset", busy_w[0], 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_serial", line_w[0], 1);
    check("async_reset_count", cnt_w[0], 0);
    check("async_reset_busy", busy_w[0], 0);
    check("async_reset_ready", rdy_w[0], 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clock);
      if (line_w[0] == 1'b0) lows++;
    end
    check("post_reset_line_low_cycles", lows, 0);
    check("post_reset_frames", frames_done[0], 1);
    check("post_reset_busy", busy_w[0], 0);

    for (int i = 0; i < N_DUT; i++)
      check($sformatf("scoreboard_drained_u%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
